// File: rtl/srff_bank_ctrl.sv
// ---------------------------------------------------------------------------
// srff_bank_ctrl
//   Sequencer and round-robin arbiter for a bank of N external SR flip-flops
//   that share clk with this block. Two requesters issue hold/set/reset/toggle
//   commands. The controller drives a registered one-hot s/r pulse for one
//   cycle and then checks the bank readback. After reset the whole bank is
//   cleared and the clear is checked before any command is accepted.
//
//   Ports
//     clk, rst            clock shared with the bank, synchronous active-high reset
//     reqX_valid/op/idx   command from requester X (op: 00 hold, 01 set,
//                         10 reset, 11 toggle)
//     reqX_ready          combinational accept, high only in IDLE for the grantee
//     q_in                q outputs of the bank
//     s_out, r_out        registered s/r inputs of the bank (never both high on a bit)
//     busy                high whenever the controller is not IDLE
//     done, done_id       one-cycle completion pulse and the requester it serves
//     err, clr_err        sticky readback error flag and its clear
// ---------------------------------------------------------------------------
module srff_bank_ctrl #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [1:0]       req0_op,
    input  logic [IDX_W-1:0] req0_idx,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_op,
    input  logic [IDX_W-1:0] req1_idx,
    output logic             req1_ready,
    input  logic [N-1:0]     q_in,
    output logic [N-1:0]     s_out,
    output logic [N-1:0]     r_out,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic             err,
    input  logic             clr_err
);

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_INIT_CHK = 3'd1,
        ST_IDLE     = 3'd2,
        ST_DRIVE    = 3'd3,
        ST_CHECK    = 3'd4
    } state_t;

    localparam logic [IDX_W:0] N_LIM = (IDX_W+1)'(N);

    // Bit of vec selected by idx; an index beyond the bank reads as 0.
    function automatic logic bit_at(input logic [N-1:0] vec, input logic [IDX_W-1:0] idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (idx == IDX_W'(i)) begin
                b = vec[i];
            end
        end
        return b;
    endfunction

    // One-hot mask for idx; an index beyond the bank yields no bit at all,
    // which is what suppresses the drive for out-of-range commands.
    function automatic logic [N-1:0] one_hot(input logic [IDX_W-1:0] idx);
        logic [N-1:0] m;
        m = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (idx == IDX_W'(i)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    state_t           state_q, state_d;
    logic [N-1:0]     s_q, s_d, r_q, r_d;
    logic             done_q, done_d, done_id_q, done_id_d;
    logic             err_q, err_d, busy_q, busy_d;
    logic             last_grant_q, last_grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             id_q, id_d, exp_q, exp_d, oor_q, oor_d;

    logic             grant0_s, grant1_s, accept_s, in_range_s, q_sel_s, err_set_s;
    logic [1:0]       sel_op_s;
    logic [IDX_W-1:0] sel_idx_s;
    logic [N-1:0]     hot_s;

    // Round-robin arbitration: on contention the requester not served last wins.
    always_comb begin
        grant0_s   = req0_valid && (!req1_valid || last_grant_q);
        grant1_s   = req1_valid && (!req0_valid || !last_grant_q);
        req0_ready = (state_q == ST_IDLE) && grant0_s;
        req1_ready = (state_q == ST_IDLE) && grant1_s;
        accept_s   = req0_ready || req1_ready;
        sel_op_s   = grant1_s ? req1_op  : req0_op;
        sel_idx_s  = grant1_s ? req1_idx : req0_idx;
        in_range_s = ({1'b0, sel_idx_s} < N_LIM);
        q_sel_s    = bit_at(q_in, sel_idx_s);
        hot_s      = one_hot(sel_idx_s);
    end

    // Next state and next registered outputs; s/r are computed for the state
    // being entered so the pulse coincides with INIT/DRIVE.
    always_comb begin
        state_d      = state_q;
        s_d          = {N{1'b0}};
        r_d          = {N{1'b0}};
        done_d       = 1'b0;
        done_id_d    = 1'b0;
        idx_d        = idx_q;
        id_d         = id_q;
        exp_d        = exp_q;
        oor_d        = oor_q;
        last_grant_d = last_grant_q;
        err_set_s    = 1'b0;
        case (state_q)
            ST_INIT: begin
                // First INIT cycle after reset loads the clear pulse; the
                // second cycle carries it to the bank and moves on.
                if (r_q == {N{1'b1}}) begin
                    state_d = ST_INIT_CHK;
                    done_d  = 1'b1;
                end else begin
                    r_d = {N{1'b1}};
                end
            end
            ST_INIT_CHK: begin
                state_d   = ST_IDLE;
                err_set_s = (q_in != {N{1'b0}});
            end
            ST_IDLE: begin
                if (accept_s) begin
                    state_d      = ST_DRIVE;
                    idx_d        = sel_idx_s;
                    id_d         = grant1_s;
                    last_grant_d = grant1_s;
                    oor_d        = !in_range_s;
                    case (sel_op_s)
                        2'b01: begin
                            exp_d = 1'b1;
                            s_d   = hot_s;
                        end
                        2'b10: begin
                            exp_d = 1'b0;
                            r_d   = hot_s;
                        end
                        2'b11: begin
                            exp_d = ~q_sel_s;
                            if (q_sel_s) begin
                                r_d = hot_s;
                            end else begin
                                s_d = hot_s;
                            end
                        end
                        default: begin
                            exp_d = q_sel_s;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                state_d   = ST_CHECK;
                done_d    = 1'b1;
                done_id_d = id_q;
            end
            ST_CHECK: begin
                state_d   = ST_IDLE;
                err_set_s = oor_q || (bit_at(q_in, idx_q) != exp_q);
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        // A new error outranks a simultaneous clear.
        if (err_set_s) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            s_q          <= {N{1'b0}};
            r_q          <= {N{1'b0}};
            done_q       <= 1'b0;
            done_id_q    <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b1;
            last_grant_q <= 1'b1;
            idx_q        <= {IDX_W{1'b0}};
            id_q         <= 1'b0;
            exp_q        <= 1'b0;
            oor_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            r_q          <= r_d;
            done_q       <= done_d;
            done_id_q    <= done_id_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
            idx_q        <= idx_d;
            id_q         <= id_d;
            exp_q        <= exp_d;
            oor_q        <= oor_d;
        end
    end

    assign s_out   = s_q;
    assign r_out   = r_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign err     = err_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_srff_bank_ctrl.sv
// Bench for srff_bank_ctrl: an SR-flop bank model, a timeline-based reference
// model (expected outputs stored per absolute cycle), a per-cycle compare
// process, directed scenarios with literal expectations, and random traffic.
module tb_srff_bank_ctrl;
    localparam int N     = 8;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic [1:0]       req0_op = 2'd0, req1_op = 2'd0;
    logic [IDX_W-1:0] req0_idx = 4'd0, req1_idx = 4'd0;
    logic             req0_ready, req1_ready;
    logic [N-1:0]     q_in, s_out, r_out;
    logic             busy, done, done_id, err;
    logic             clr_err = 1'b0;

    logic [N-1:0]     bank_q;
    logic [N-1:0]     bank_seed = 8'h00;
    logic             bank_load = 1'b0;
    logic [N-1:0]     stuck0 = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    srff_bank_ctrl #(.N(N), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_idx(req0_idx), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_idx(req1_idx), .req1_ready(req1_ready),
        .q_in(q_in), .s_out(s_out), .r_out(r_out), .busy(busy),
        .done(done), .done_id(done_id), .err(err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    // External SR flop bank; stuck0 forces chosen readback bits low.
    always @(posedge clk) begin
        if (bank_load) begin
            bank_q <= bank_seed;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (s_out[i] && !r_out[i]) bank_q[i] <= 1'b1;
                else if (r_out[i] && !s_out[i]) bank_q[i] <= 1'b0;
            end
        end
    end
    assign q_in = bank_q & ~stuck0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // ---------------- reference model: timeline of expected outputs -------
    logic [N-1:0] e_s[int];
    logic [N-1:0] e_r[int];
    bit           e_done[int];
    bit           e_id[int];
    int  idle_from = 0;
    int  chk_cyc = -10;
    bit  chk_init, chk_oor, chk_exp;
    int  chk_idx;
    bit  m_err = 0, m_last = 1, m_valid = 0;

    initial begin
        forever begin
            int p;
            @(posedge clk);
            p = cyc;        // cycle that ends at this edge
            cyc = cyc + 1;  // cycle that starts now
            if (rst) begin
                e_s.delete(); e_r.delete(); e_done.delete(); e_id.delete();
                m_valid = 1; m_err = 0; m_last = 1;
                e_r[cyc + 1] = 8'hFF;
                e_done[cyc + 2] = 1'b1; e_id[cyc + 2] = 1'b0;
                chk_cyc = cyc + 2; chk_init = 1'b1;
                idle_from = cyc + 3;
            end else if (m_valid) begin
                bit set_e;
                set_e = 1'b0;
                if (p == chk_cyc) begin
                    if (chk_init) set_e = (q_in != 8'h00);
                    else set_e = chk_oor || (q_in[chk_idx] != chk_exp);
                end
                if (set_e) m_err = 1'b1;
                else if (clr_err) m_err = 1'b0;
                if (p >= idle_from && (req0_valid || req1_valid)) begin
                    bit g, qv;
                    int ix, op;
                    g  = (req0_valid && req1_valid) ? !m_last : req1_valid;
                    ix = g ? int'(req1_idx) : int'(req0_idx);
                    op = g ? int'(req1_op)  : int'(req0_op);
                    qv = (ix < N) ? q_in[ix] : 1'b0;
                    chk_oor = (ix >= N);
                    chk_idx = chk_oor ? 0 : ix;
                    chk_exp = (op == 1) ? 1'b1 : (op == 2) ? 1'b0 : (op == 3) ? !qv : qv;
                    if (!chk_oor) begin
                        if (op == 1 || (op == 3 && !qv)) e_s[p + 1] = 8'(1) << ix;
                        if (op == 2 || (op == 3 && qv))  e_r[p + 1] = 8'(1) << ix;
                    end
                    e_done[p + 2] = 1'b1; e_id[p + 2] = g;
                    chk_cyc = p + 2; chk_init = 1'b0;
                    idle_from = p + 3;
                    m_last = g;
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model ------------------
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                logic [N-1:0] es, er;
                bit ed, r0, r1, idle;
                es   = e_s.exists(cyc) ? e_s[cyc] : 8'h00;
                er   = e_r.exists(cyc) ? e_r[cyc] : 8'h00;
                ed   = e_done.exists(cyc) ? e_done[cyc] : 1'b0;
                idle = (cyc >= idle_from);
                r0   = idle && req0_valid && (!req1_valid || m_last);
                r1   = idle && req1_valid && (!req0_valid || !m_last);
                chk("s_out", s_out, es);
                chk("r_out", r_out, er);
                chk("s_and_r", s_out & r_out, 64'd0);
                chk("done", done, ed);
                if (ed) chk("done_id", done_id, e_id[cyc]);
                chk("busy", busy, !idle);
                chk("err", err, m_err);
                chk("req0_ready", req0_ready, r0);
                chk("req1_ready", req1_ready, r1);
            end
        end
    end

    // Issue a command and wait (bounded) for its handshake; returns in DRIVE.
    task automatic issue(input bit who, input logic [1:0] op, input logic [IDX_W-1:0] idx,
                         output int acc);
        acc = -1;
        if (who) begin req1_valid = 1'b1; req1_op = op; req1_idx = idx; end
        else     begin req0_valid = 1'b1; req0_op = op; req0_idx = idx; end
        for (int k = 0; k < 30 && acc < 0; k++) begin
            #1;
            if ((who && req1_ready) || (!who && req0_ready)) acc = cyc;
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        if (acc < 0) chk("handshake_timeout", 64'd0, 64'd1);
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, a3;
        int order[$];
        bit took0, took1;

        // Reset with random bank contents.
        bank_seed = 8'($urandom); bank_load = 1'b1;
        @(posedge clk); #1; bank_load = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        step(1); chk("init_r_ff", r_out, 64'hFF); chk("init_s0", s_out, 64'h00);
        step(1); chk("init_done", done, 64'd1); chk("init_done_id", done_id, 64'd0);
        step(1); chk("init_err", err, 64'd0); chk("init_idle", busy, 64'd0);

        // Single set.
        issue(1'b0, 2'b01, 4'd5, a1);
        chk("set_s", s_out, 64'h20); chk("set_r", r_out, 64'h00);
        step(1); chk("set_done", done, 64'd1); chk("set_id", done_id, 64'd0);
        chk("set_q5", q_in[5], 64'd1);
        step(1); chk("set_err", err, 64'd0);

        // Toggle idx 2 three times from 0.
        issue(1'b1, 2'b11, 4'd2, a1); chk("tg1_s", s_out, 64'h04);
        issue(1'b1, 2'b11, 4'd2, a2); chk("tg2_r", r_out, 64'h04);
        issue(1'b1, 2'b11, 4'd2, a3); chk("tg3_s", s_out, 64'h04);
        chk("tg_gap1", a2 - a1, 64'd3); chk("tg_gap2", a3 - a2, 64'd3);
        step(1); chk("tg_q2", q_in[2], 64'd1); chk("tg_done_id", done_id, 64'd1);

        // Contention: grants must alternate starting with req0.
        req0_valid = 1'b1; req0_op = 2'b01; req0_idx = 4'd0;
        req1_valid = 1'b1; req1_op = 2'b10; req1_idx = 4'd1;
        for (int k = 0; k < 12; k++) begin
            #1;
            chk("both_ready", req0_ready & req1_ready, 64'd0);
            if (req0_ready) order.push_back(0);
            if (req1_ready) order.push_back(1);
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("cont_grants", order.size(), 64'd4);
        if (order.size() >= 4) begin
            chk("cont_g0", order[0], 64'd0); chk("cont_g1", order[1], 64'd1);
            chk("cont_g2", order[2], 64'd0); chk("cont_g3", order[3], 64'd1);
        end
        step(2);

        // Out-of-range index.
        issue(1'b0, 2'b01, 4'd9, a1);
        chk("oor_s", s_out, 64'h00); chk("oor_r", r_out, 64'h00);
        step(2); chk("oor_err", err, 64'd1);
        clr_err = 1'b1; step(1); clr_err = 1'b0; chk("clr_err", err, 64'd0);

        // Stuck-at-0 readback on bit 3.
        stuck0 = 8'h08;
        issue(1'b0, 2'b01, 4'd3, a1);
        step(2); chk("stuck_err", err, 64'd1);
        stuck0 = 8'h00;
        clr_err = 1'b1; step(1); clr_err = 1'b0;

        // Reset during DRIVE drops the command.
        issue(1'b0, 2'b01, 4'd6, a1);
        rst = 1'b1; step(1);
        chk("mr_s", s_out, 64'h00); chk("mr_r", r_out, 64'h00);
        chk("mr_err", err, 64'd0); chk("mr_busy", busy, 64'd1);
        rst = 1'b0; step(1); chk("mr_no_done", done, 64'd0);
        step(3);

        // Random traffic against the model.
        took0 = 1'b0; took1 = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(posedge clk); #1;
            if (took0) req0_valid = 1'b0;
            if (took1) req1_valid = 1'b0;
            if (!req0_valid && $urandom_range(2, 0) == 0) begin
                req0_valid = 1'b1; req0_op = 2'($urandom_range(3, 0));
                req0_idx = 4'($urandom_range(9, 0));
            end
            if (!req1_valid && $urandom_range(2, 0) == 0) begin
                req1_valid = 1'b1; req1_op = 2'($urandom_range(3, 0));
                req1_idx = 4'($urandom_range(9, 0));
            end
            clr_err = ($urandom_range(15, 0) == 0);
            rst     = ($urandom_range(99, 0) == 0);
            #1;
            took0 = req0_valid && req0_ready;
            took1 = req1_valid && req1_ready;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; clr_err = 1'b0; rst = 1'b0;
        step(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/srff_bank_ctrl.md
Name: srff_bank_ctrl

Overview:
Sequencer and arbiter for a bank of N external srff flip-flops, all clocked on the same clk as this block. It takes set/reset/toggle/hold commands from two requesters, grants them round-robin, and drives one-hot s/r pulses. It never asserts s and r together on any bit, and reads q back to verify every operation. After reset it clears the whole bank and verifies the clear before accepting commands.

Parameters:
N, 8, number of SR flops in the bank (2..64)
IDX_W, 3, width of bit index; must satisfy 2**IDX_W >= N

Ports:
clk  in  1  clock; shared with the srff bank
rst  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 command valid
req0_op  in  2  00 hold, 01 set, 10 reset, 11 toggle
req0_idx  in  IDX_W  target bit
req0_ready  out  1  requester 0 accept (combinational)
req1_valid, req1_op, req1_idx, req1_ready  same as requester 0, for requester 1
q_in  in  N  q outputs of the bank
s_out  out  N  s inputs of the bank, registered
r_out  out  N  r inputs of the bank, registered
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse in CHECK and INIT_CHK
done_id  out  1  requester served by the current done (0 during INIT_CHK)
err  out  1  sticky error flag
clr_err  in  1  clears err (rst also clears it)

Behaviour:
- States: INIT, INIT_CHK, IDLE, DRIVE, CHECK. Registered state.
- Reset, including mid-operation: state=INIT. Outputs s_out=0, r_out=0, err=0, done=0, last_grant=1, pending command cleared.
- INIT: r_out set to all ones for one cycle, s_out=0. Next state INIT_CHK.
- INIT_CHK: s_out=r_out=0; done=1, done_id=0.
  - If q_in != 0, set err.
  - Next state IDLE.
- IDLE: ready is high only here.
  - Grant: if only one req valid, grant it. If both valid, grant the one != last_grant (after reset, req0 wins first).
  - reqX_ready = (state==IDLE) && grantX. Both ready signals are never high together.
  - On handshake: latch op, idx and requester id; update last_grant; next state DRIVE.
- DRIVE: exactly one cycle.
  - Set: s_out[idx]=1.
  - Reset: r_out[idx]=1.
  - Toggle: uses q_in[idx] sampled at accept. If it was 1, r_out[idx]=1; otherwise s_out[idx]=1.
  - Hold: no drive.
  - idx >= N: no drive, and err set in CHECK.
  - Expected value is latched at accept: set gives 1, reset gives 0, toggle gives ~q_in[idx], hold gives q_in[idx].
  - All other s_out/r_out bits are 0. s_out & r_out == 0 at all times.
- CHECK: s_out=r_out=0; done=1, done_id=latched id.
  - If q_in[idx] != expected, or idx was out of range, set err.
  - Next state IDLE.
- Timing:
  - Latency from accept (cycle T) to done is 2 cycles: DRIVE at T+1, CHECK at T+2.
  - Next accept possible at T+3.
  - Sustained throughput is 1 command per 3 cycles.
- err:
  - Set has priority over clr_err in the same cycle.
  - err is never cleared by IDLE.
- Requests held valid without ready must be kept stable by the requester. The controller samples op/idx only at the handshake.

Test Plan:
- Reset then idle: rst high 2 cycles, bank q random -> r_out=8'hFF for 1 cycle; INIT_CHK done=1, err=0 with model q=0; first readyX appears 3 cycles after rst falls.
- Single set: req0 op=01 idx=5 -> s_out=8'h20 for exactly 1 cycle, r_out=0; q[5]=1; done=1, done_id=0 two cycles after accept; err=0.
- Toggle sequence: req1 toggle idx=2 three times, starting from q=0 -> alternating s_out=8'h04, r_out=8'h04, s_out=8'h04; final q[2]=1; three done pulses spaced 3 cycles apart.
- Contention: both valid continuously with req0 set idx0 and req1 reset idx1 -> grants alternate 0,1,0,1 starting with req0; ready never high simultaneously; s_out & r_out == 0 on every cycle.
- Faults: idx=9 with N=8 -> no drive, err=1 at CHECK. clr_err then sets err=0. Model with stuck-at-0 q[3] and set idx3 -> err=1.
- Mid-operation reset: assert rst during DRIVE -> next cycle s_out=r_out=0, state INIT, err=0, and the pending command is dropped (no done for it).
